mc_ctrl: RTL and testbench

Multicycle MIPS control FSM that drives the next-PC unit's control inputs (turn, branch, jump) and produces the datapath write enables and mux selects. It sits between the instruction register (op/funct) and the ALU flags (zero, more), and sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of the control codes that the next-PC logic consumes.

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl_dec.sv | 47 ++++
 rtl/mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: branch/jump codes,
// opcodes, functs, ALU operations, FSM states and instruction classes.
package mc_ctrl_pkg;

  typedef enum logic [1:0] {NOBR = 2'b00, BEQ = 2'b01, BNE = 2'b10, BGTZ = 2'b11} br_t;
  typedef enum logic [1:0] {NOJ = 2'b00, J = 2'b01, JAL = 2'b10, JR = 2'b11} jmp_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_OR    = 3'd2,
    ALU_SLT   = 3'd3,
    ALU_LUI   = 3'd4,
    ALU_PASSA = 3'd5
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_BRANCH, C_JUMP, C_ILLEGAL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_SLT    = 6'h2A;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the instruction register/ALU flags and the control FSM.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       more;
  logic       pcwr;
  logic       turn;
  logic [1:0] branch;
  logic [1:0] jump;
  logic       irwr;
  logic       regwr;
  logic [1:0] regdst;
  logic       alusrc;
  logic [2:0] aluop;
  logic       extop;
  logic       memwr;
  logic [1:0] memtoreg;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  // Controller side
  modport master (
    input  op, funct, zero, more,
    output pcwr, turn, branch, jump, irwr, regwr, regdst, alusrc, aluop,
           extop, memwr, memtoreg, retire, illegal, state
  );

  // Datapath side
  modport slave (
    output op, funct, zero, more,
    input  pcwr, turn, branch, jump, irwr, regwr, regdst, alusrc, aluop,
           extop, memwr, memtoreg, retire, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational op/funct decoder: instruction class plus the ALU, extension,
// branch and jump controls that apply while the instruction executes.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output aluop_t     aluop,
  output logic       alusrc,
  output logic       extop,
  output br_t        br,
  output jmp_t       jmp
);

  always_comb begin
    cls    = C_ILLEGAL;
    aluop  = ALU_ADD;
    alusrc = 1'b0;
    extop  = 1'b0;
    br     = NOBR;
    jmp    = NOJ;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: cls = C_RTYPE;
          F_SUBU: begin cls = C_RTYPE; aluop = ALU_SUB; end
          F_SLT:  begin cls = C_RTYPE; aluop = ALU_SLT; end
          F_JR:   begin cls = C_JUMP;  aluop = ALU_PASSA; jmp = JR; end
          default: ;
        endcase
      end
      OP_ORI:  begin cls = C_ITYPE; aluop = ALU_OR;  alusrc = 1'b1; end
      OP_LUI:  begin cls = C_ITYPE; aluop = ALU_LUI; alusrc = 1'b1; end
      OP_ADDI: begin cls = C_ITYPE; alusrc = 1'b1; extop = 1'b1; end
      OP_LW:   begin cls = C_LOAD;  alusrc = 1'b1; extop = 1'b1; end
      OP_SW:   begin cls = C_STORE; alusrc = 1'b1; extop = 1'b1; end
      OP_BEQ:  begin cls = C_BRANCH; aluop = ALU_SUB;   br = BEQ;  end
      OP_BNE:  begin cls = C_BRANCH; aluop = ALU_SUB;   br = BNE;  end
      OP_BGTZ: begin cls = C_BRANCH; aluop = ALU_PASSA; br = BGTZ; end
      OP_J:    begin cls = C_JUMP; jmp = J;   end
      OP_JAL:  begin cls = C_JUMP; jmp = JAL; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the next-PC codes, write enables and datapath mux selects.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  state_t     st, nxt;
  logic [5:0] op_q, funct_q;
  logic       ill_q, ill_set;

  cls_t       d_cls;
  aluop_t     d_aluop;
  logic       d_alusrc, d_extop;
  br_t        d_br;
  jmp_t       d_jmp;

  logic       pcwr_c, turn_c, irwr_c, regwr_c, alusrc_c, extop_c, memwr_c, retire_c;
  logic [1:0] regdst_c, memtoreg_c;
  aluop_t     aluop_c;
  br_t        br_c;
  jmp_t       jmp_c;

  // DECODE steers on the live IR; later states use the copy captured there.
  mc_ctrl_dec u_dec (
    .op     ((st == S_DECODE) ? bus.op    : op_q),
    .funct  ((st == S_DECODE) ? bus.funct : funct_q),
    .cls    (d_cls),
    .aluop  (d_aluop),
    .alusrc (d_alusrc),
    .extop  (d_extop),
    .br     (d_br),
    .jmp    (d_jmp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      ill_q   <= 1'b0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      st <= nxt;
      if (st == S_DECODE) begin
        op_q    <= bus.op;
        funct_q <= bus.funct;
      end
      if (ill_set) ill_q <= 1'b1;
    end
  end

  always_comb begin
    nxt        = S_FETCH;
    ill_set    = 1'b0;
    pcwr_c     = 1'b0;
    turn_c     = 1'b0;
    irwr_c     = 1'b0;
    regwr_c    = 1'b0;
    alusrc_c   = 1'b0;
    extop_c    = 1'b0;
    memwr_c    = 1'b0;
    retire_c   = 1'b0;
    regdst_c   = 2'd0;
    memtoreg_c = 2'd0;
    aluop_c    = ALU_ADD;
    br_c       = NOBR;
    jmp_c      = NOJ;
    case (st)
      S_FETCH: begin
        irwr_c = 1'b1;
        turn_c = 1'b1;
        pcwr_c = 1'b1;
        nxt    = S_DECODE;
      end
      S_DECODE: begin
        case (d_cls)
          C_LOAD, C_STORE:  nxt = S_MEMADR;
          C_RTYPE, C_ITYPE: nxt = S_EXE;
          C_BRANCH:         nxt = S_BRANCH;
          C_JUMP:           nxt = S_JUMP;
          default: begin
            ill_set  = 1'b1;
            retire_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluop_c  = d_aluop;
        alusrc_c = d_alusrc;
        extop_c  = d_extop;
        nxt      = (d_cls == C_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: nxt = S_MEMWB;
      S_MEMWB: begin
        regwr_c    = 1'b1;
        memtoreg_c = 2'd1;
        retire_c   = 1'b1;
      end
      S_MEMWR: begin
        memwr_c  = 1'b1;
        retire_c = 1'b1;
      end
      S_EXE: begin
        aluop_c  = d_aluop;
        alusrc_c = d_alusrc;
        extop_c  = d_extop;
        nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        regwr_c  = 1'b1;
        regdst_c = (d_cls == C_RTYPE) ? 2'd1 : 2'd0;
        retire_c = 1'b1;
      end
      S_BRANCH: begin
        aluop_c  = d_aluop;
        br_c     = d_br;
        retire_c = 1'b1;
        case (d_br)
          BEQ:     pcwr_c = bus.zero;
          BNE:     pcwr_c = ~bus.zero;
          BGTZ:    pcwr_c = bus.more;
          default: pcwr_c = 1'b0;
        endcase
      end
      S_JUMP: begin
        pcwr_c   = 1'b1;
        retire_c = 1'b1;
        jmp_c    = d_jmp;
        aluop_c  = d_aluop;
        if (d_jmp == JAL) begin
          regwr_c    = 1'b1;
          regdst_c   = 2'd2;
          memtoreg_c = 2'd2;
        end
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset holds every output at zero regardless of the registered state.
  assign bus.pcwr     = rst_n & pcwr_c;
  assign bus.turn     = rst_n & turn_c;
  assign bus.irwr     = rst_n & irwr_c;
  assign bus.regwr    = rst_n & regwr_c;
  assign bus.alusrc   = rst_n & alusrc_c;
  assign bus.extop    = rst_n & extop_c;
  assign bus.memwr    = rst_n & memwr_c;
  assign bus.retire   = rst_n & retire_c;
  assign bus.illegal  = rst_n & ill_q;
  assign bus.regdst   = rst_n ? regdst_c   : 2'd0;
  assign bus.memtoreg = rst_n ? memtoreg_c : 2'd0;
  assign bus.aluop    = rst_n ? aluop_c    : ALU_ADD;
  assign bus.branch   = rst_n ? br_c       : NOBR;
  assign bus.jump     = rst_n ? jmp_c      : NOJ;
  assign bus.state    = rst_n ? st         : S_FETCH;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instruction streams
// compared cycle by cycle against a per-instruction reference schedule.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       pcwr, turn;
    logic [1:0] branch, jump;
    logic       irwr, regwr;
    logic [1:0] regdst;
    logic       alusrc;
    logic [2:0] aluop;
    logic       extop, memwr;
    logic [1:0] memtoreg;
    logic       retire;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nfail = 0;
  logic ill_exp = 1'b0;
  int   zf = -1;
  int   mf = -1;

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [11:0] legal [15] = '{
    {OP_RTYPE, F_ADDU}, {OP_RTYPE, F_SUBU}, {OP_RTYPE, F_SLT}, {OP_RTYPE, F_JR},
    {OP_ORI, 6'h00}, {OP_LUI, 6'h11}, {OP_ADDI, 6'h05}, {OP_LW, 6'h00},
    {OP_SW, 6'h3C}, {OP_BEQ, 6'h00}, {OP_BNE, 6'h21}, {OP_BGTZ, 6'h00},
    {OP_J, 6'h08}, {OP_JAL, 6'h00}, {OP_LW, 6'h2A}
  };

  function automatic logic is_rtype_ok(input logic [5:0] f);
    return (f == F_ADDU) || (f == F_SUBU) || (f == F_SLT) || (f == F_JR);
  endfunction

  function automatic logic ref_illegal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_RTYPE: return !is_rtype_ok(f);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Instruction length in cycles including fetch and decode.
  function automatic int unsigned ref_len(input logic [5:0] o, input logic [5:0] f);
    if (ref_illegal(o, f)) return 2;
    case (o)
      OP_LW: return 5;
      OP_SW, OP_ADDI, OP_ORI, OP_LUI: return 4;
      OP_RTYPE: return (f == F_JR) ? 3 : 4;
      default: return 3;
    endcase
  endfunction

  // Expected outputs in cycle k of instruction (o,f) under flags z/m.
  function automatic vec_t ref_out(input logic [5:0] o, input logic [5:0] f,
                                   input int unsigned k, input logic z, input logic m);
    vec_t e;
    logic rt;
    e  = '0;
    rt = (o == OP_RTYPE);
    if (k == 0) begin
      e.state = 4'd0; e.irwr = 1'b1; e.turn = 1'b1; e.pcwr = 1'b1;
    end else if (k == 1) begin
      e.state = 4'd1; e.retire = ref_illegal(o, f);
    end else if (o == OP_LW || o == OP_SW) begin
      if (k == 2) begin
        e.state = 4'd2; e.alusrc = 1'b1; e.extop = 1'b1; e.aluop = ALU_ADD;
      end else if (o == OP_SW) begin
        e.state = 4'd5; e.memwr = 1'b1; e.retire = 1'b1;
      end else if (k == 3) begin
        e.state = 4'd3;
      end else begin
        e.state = 4'd4; e.regwr = 1'b1; e.memtoreg = 2'd1; e.retire = 1'b1;
      end
    end else if (o == OP_BEQ || o == OP_BNE || o == OP_BGTZ) begin
      e.state = 4'd8; e.retire = 1'b1;
      if (o == OP_BEQ)      begin e.branch = BEQ;  e.aluop = ALU_SUB;   e.pcwr = z;  end
      else if (o == OP_BNE) begin e.branch = BNE;  e.aluop = ALU_SUB;   e.pcwr = !z; end
      else                  begin e.branch = BGTZ; e.aluop = ALU_PASSA; e.pcwr = m;  end
    end else if (o == OP_J || o == OP_JAL || (rt && f == F_JR)) begin
      e.state = 4'd9; e.pcwr = 1'b1; e.retire = 1'b1;
      if (o == OP_J) e.jump = J;
      else if (o == OP_JAL) begin
        e.jump = JAL; e.regwr = 1'b1; e.regdst = 2'd2; e.memtoreg = 2'd2;
      end else begin
        e.jump = JR; e.aluop = ALU_PASSA;
      end
    end else if (k == 2) begin
      e.state = 4'd6;
      if (rt) e.aluop = (f == F_SUBU) ? ALU_SUB : (f == F_SLT) ? ALU_SLT : ALU_ADD;
      else if (o == OP_ORI) begin e.aluop = ALU_OR;  e.alusrc = 1'b1; end
      else if (o == OP_LUI) begin e.aluop = ALU_LUI; e.alusrc = 1'b1; end
      else begin e.aluop = ALU_ADD; e.alusrc = 1'b1; e.extop = 1'b1; end
    end else begin
      e.state = 4'd7; e.regwr = 1'b1; e.regdst = rt ? 2'd1 : 2'd0; e.retire = 1'b1;
    end
    return e;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v.state = bus.state;   v.pcwr = bus.pcwr;     v.turn = bus.turn;
    v.branch = bus.branch; v.jump = bus.jump;     v.irwr = bus.irwr;
    v.regwr = bus.regwr;   v.regdst = bus.regdst; v.alusrc = bus.alusrc;
    v.aluop = bus.aluop;   v.extop = bus.extop;   v.memwr = bus.memwr;
    v.memtoreg = bus.memtoreg; v.retire = bus.retire;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t exp_v, input logic exp_ill);
    vec_t obs;
    obs = sample();
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs, exp_v);
    end
    ncmp++;
    assert (bus.illegal === exp_ill) else begin
      nfail++;
      $error("FAIL %s illegal: observed %b expected %b", tag, bus.illegal, exp_ill);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_instr(input string tag, input logic [11:0] ins, input int unsigned ncyc);
    logic [5:0] o, f;
    int unsigned n;
    o = ins[11:6];
    f = ins[5:0];
    n = ref_len(o, f);
    if (ncyc < n) n = ncyc;
    for (int unsigned k = 0; k < n; k++) begin
      if (k == 0) begin
        bus.op = 6'($urandom); bus.funct = 6'($urandom);
      end else begin
        bus.op = o; bus.funct = f;
      end
      bus.zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      bus.more = (mf < 0) ? 1'($urandom) : 1'(mf);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), ref_out(o, f, k, bus.zero, bus.more), ill_exp);
      if (k == 1 && ref_illegal(o, f)) ill_exp = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.op    = '0;
    bus.funct = '0;
    bus.zero  = 1'b0;
    bus.more  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.op = 6'($urandom);
      @(negedge clk);
      check("reset", '0, 1'b0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;

    run_instr("addu", {OP_RTYPE, F_ADDU}, 99);
    run_instr("lw",   {OP_LW, 6'h00}, 99);
    run_instr("sw",   {OP_SW, 6'h00}, 99);
    zf = 1; run_instr("beq_t", {OP_BEQ, 6'h00}, 99);
    zf = 0; run_instr("beq_n", {OP_BEQ, 6'h00}, 99);
    zf = 0; run_instr("bne_t", {OP_BNE, 6'h00}, 99);
    zf = 1; run_instr("bne_n", {OP_BNE, 6'h00}, 99);
    zf = -1;
    mf = 1; run_instr("bgtz_t", {OP_BGTZ, 6'h00}, 99);
    mf = 0; run_instr("bgtz_n", {OP_BGTZ, 6'h00}, 99);
    mf = -1;
    run_instr("jal",  {OP_JAL, 6'h00}, 99);
    run_instr("jr",   {OP_RTYPE, F_JR}, 99);
    run_instr("j",    {OP_J, 6'h00}, 99);
    run_instr("subu", {OP_RTYPE, F_SUBU}, 99);
    run_instr("slt",  {OP_RTYPE, F_SLT}, 99);
    run_instr("ori",  {OP_ORI, 6'h00}, 99);
    run_instr("lui",  {OP_LUI, 6'h00}, 99);
    run_instr("addi", {OP_ADDI, 6'h00}, 99);

    for (int i = 0; i < 30; i++)
      run_instr($sformatf("rnd%0d", i), legal[$urandom_range(14)], 99);

    run_instr("ill_op", {6'h3F, 6'h00}, 99);
    run_instr("after_ill", {OP_RTYPE, F_ADDU}, 99);
    run_instr("ill_funct", {OP_RTYPE, 6'h00}, 99);

    for (int i = 0; i < 20; i++)
      run_instr($sformatf("rndb%0d", i), legal[$urandom_range(14)], 99);

    // Abandon a load in MEMRD: outputs forced low, then a clean fetch.
    run_instr("lw_cut", {OP_LW, 6'h00}, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_memrd", '0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ill_exp = 1'b0;
    run_instr("post_rst", {OP_RTYPE, F_ADDU}, 99);
    run_instr("post_rst_sw", {OP_SW, 6'h00}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
